// File: rtl/wb_pipe_master.sv
// wb_pipe_master: command/response front end driving a Wishbone pipelined-mode master
// Ports: i_clk/i_reset_n clock and async active-low reset;
//   i_cmd_stb/i_cmd_word/o_cmd_busy command in ([DW+1:DW] opcode, [DW-1:0] payload);
//   o_rsp_stb/o_rsp_word response out ([DW+1:DW] type, [DW-1:0] payload);
//   o_wb_* / i_wb_* Wishbone pipelined master bus.
module wb_pipe_master #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_cmd_stb,
  input  logic [DW+1:0]   i_cmd_word,
  output logic            o_cmd_busy,
  output logic            o_rsp_stb,
  output logic [DW+1:0]   o_rsp_word,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [AW-1:0]      addr_r, addr_nx, eaddr;
  logic               inc_r, err_d;
  logic [3:0]         cnt, cnt_n, wi;
  logic [TW-1:0]      tcnt;
  logic [MAX_OUT-1:0] we_q, we_n;
  logic [AW-1:0]      ad_q [MAX_OUT];
  logic [AW-1:0]      ad_n [MAX_OUT];
  logic [1:0]         op;
  logic               abort, acc_rw, acc_set, iss, ack_v, err_v, cnting, tmo, kill, stb_n;
  assign op      = i_cmd_word[DW+1:DW];
  assign o_wb_sel = '1;
  // A waiting request counts against the limit so a newly accepted one can always issue.
  assign o_cmd_busy = (o_wb_stb & i_wb_stall) | (32'(cnt) + 32'(o_wb_stb) >= 32'(MAX_OUT)) | err_d;
  assign abort   = i_cmd_stb & (op == 2'b11);
  assign acc_rw  = i_cmd_stb & ~o_cmd_busy & ~op[1];
  assign acc_set = i_cmd_stb & ~o_cmd_busy & (op == 2'b10);
  assign iss     = o_wb_stb & ~i_wb_stall;
  assign ack_v   = o_wb_cyc & i_wb_ack & (cnt != 4'd0);
  assign err_v   = o_wb_cyc & i_wb_err;
  assign cnting  = ((cnt != 4'd0) | o_wb_stb) & ~ack_v & ~err_v;
  assign tmo     = (TIMEOUT != 0) & cnting & (tcnt == TW'(TIMEOUT - 1));
  assign kill    = abort | err_v | tmo;
  assign cnt_n   = cnt + 4'(iss) - 4'(ack_v);
  assign wi      = cnt - 4'(ack_v);
  assign stb_n   = acc_rw | (o_wb_stb & ~iss);
  assign addr_nx = (iss & inc_r) ? addr_r + AW'(1) : addr_r;
  // The oldest outstanding transfer is the one an err refers to.
  assign eaddr   = cnt != 4'd0 ? ad_q[0] : o_wb_addr;
  always_comb begin
    we_n = ack_v ? we_q >> 1 : we_q;
    ad_n = ad_q;
    if (ack_v)
      for (int i = 0; i < MAX_OUT - 1; i++) ad_n[i] = ad_q[i+1];
    for (int i = 0; i < MAX_OUT; i++)
      if (iss && 4'(i) == wi) begin
        we_n[i] = o_wb_we;
        ad_n[i] = o_wb_addr;
      end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_r     <= '0;
      inc_r      <= 1'b0;
      err_d      <= 1'b0;
      cnt        <= '0;
      tcnt       <= '0;
      we_q       <= '0;
      for (int i = 0; i < MAX_OUT; i++) ad_q[i] <= '0;
      o_rsp_stb  <= 1'b0;
      o_rsp_word <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
    end else begin
      err_d      <= ~abort & (err_v | tmo);
      o_rsp_stb  <= kill | ack_v;
      o_rsp_word <= abort ? {2'b11, {DW{1'b0}}} :
                    err_v ? {2'b10, DW'(eaddr)} :
                    tmo   ? {2'b10, {DW{1'b1}}} :
                    ack_v ? {1'b0, we_q[0], we_q[0] ? {DW{1'b0}} : i_wb_data} : o_rsp_word;
      o_wb_stb   <= ~kill & stb_n;
      o_wb_cyc   <= ~kill & (stb_n | (cnt_n != 4'd0));
      cnt        <= kill ? 4'd0 : cnt_n;
      tcnt       <= (cnting & ~kill) ? tcnt + TW'(1) : '0;
      we_q       <= we_n;
      ad_q       <= ad_n;
      addr_r     <= acc_set ? i_cmd_word[AW-1:0] : addr_nx;
      if (acc_set) inc_r <= i_cmd_word[DW-1];
      if (acc_rw) begin
        o_wb_we   <= op[0];
        o_wb_addr <= addr_nx;
        o_wb_data <= i_cmd_word[DW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_wb_pipe_master.sv
// tb_wb_pipe_master: randomized and directed checks of wb_pipe_master against a transaction model
module tb_wb_pipe_master;
  localparam int AW = 30, DW = 32, MO = 4, TO = 8;
  typedef struct packed {logic we; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;
  logic clk = 1'b0;
  logic rst_n, cmd_stb, cmd_busy, rsp_stb, wb_cyc, wb_stb, wb_we, wb_stall, wb_ack, wb_err;
  logic [DW+1:0] cmd_word, rsp_word;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata, wb_rdata;
  logic [DW/8-1:0] wb_sel;
  req_t pq[$], oq[$];
  logic [AW-1:0] m_addr;
  logic m_inc, m_errd, ex_v;
  logic [DW+1:0] ex_w;
  int run, n_cmp, n_bad;
  always #5 clk = ~clk;
  wb_pipe_master #(.AW(AW), .DW(DW), .MAX_OUT(MO), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_stb(cmd_stb), .i_cmd_word(cmd_word),
    .o_cmd_busy(cmd_busy), .o_rsp_stb(rsp_stb), .o_rsp_word(rsp_word),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
    .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW+1:0] cw(input logic [1:0] op, input logic [DW-1:0] pl);
    return {op, pl};
  endfunction
  task automatic reset_model();
    pq.delete(); oq.delete();
    m_addr = '0; m_inc = 0; m_errd = 0; ex_v = 0; ex_w = '0; run = 0;
  endtask
  task automatic rst_checks(input string t);
    check({t, "_cyc"}, wb_cyc, 0);
    check({t, "_stb"}, wb_stb, 0);
    check({t, "_we"}, wb_we, 0);
    check({t, "_rsp_stb"}, rsp_stb, 0);
    check({t, "_busy"}, cmd_busy, 0);
    check({t, "_addr"}, wb_addr, 0);
    check({t, "_data"}, wb_wdata, 0);
    check({t, "_rsp_word"}, rsp_word, 0);
    check({t, "_sel"}, wb_sel, 4'hF);
  endtask
  // One clock: drive inputs, compare outputs with the model, then advance the model over the edge.
  task automatic step(input logic cs, input logic [DW+1:0] w, input logic st, input logic ak,
                      input logic er, input logic [DW-1:0] rd);
    logic e_stb, e_cyc, e_busy, acc, errv, ackv, counting, abt, tmo;
    logic [1:0] op;
    req_t r;
    @(negedge clk);
    cmd_stb = cs; cmd_word = w; wb_stall = st; wb_ack = ak; wb_err = er; wb_rdata = rd;
    #1;
    e_stb  = pq.size() > 0;
    e_cyc  = e_stb || oq.size() > 0;
    e_busy = (e_stb && st) || (pq.size() + oq.size() >= MO) || m_errd;
    check("cyc", wb_cyc, e_cyc);
    check("stb", wb_stb, e_stb);
    check("busy", cmd_busy, e_busy);
    check("rsp_stb", rsp_stb, ex_v);
    if (ex_v) check("rsp_word", rsp_word, ex_w);
    if (e_stb) begin
      check("we", wb_we, pq[0].we);
      check("addr", wb_addr, pq[0].a);
      if (pq[0].we) check("wdata", wb_wdata, pq[0].d);
    end
    @(posedge clk);
    op = w[DW+1:DW];
    acc = cs && (!e_busy || op == 2'b11);
    abt = acc && op == 2'b11;
    errv = er && e_cyc;
    ackv = ak && oq.size() > 0;
    counting = e_cyc && !ackv && !errv;
    tmo = counting && run == TO - 1;
    if (e_stb && !st) m_addr = m_addr + AW'(m_inc);
    ex_v = 0;
    if (abt || errv || tmo) begin
      ex_v = 1;
      ex_w = abt ? {2'b11, {DW{1'b0}}} :
             errv ? {2'b10, DW'(oq.size() > 0 ? oq[0].a : pq[0].a)} : {2'b10, {DW{1'b1}}};
      m_errd = !abt; run = 0;
      pq.delete(); oq.delete();
    end else begin
      m_errd = 0;
      run = counting ? run + 1 : 0;
      if (ackv) begin
        r = oq.pop_front();
        ex_v = 1;
        ex_w = r.we ? {2'b01, {DW{1'b0}}} : {2'b00, rd};
      end
      if (e_stb && !st) oq.push_back(pq.pop_front());
      if (acc && !op[1]) begin
        r.we = op[0]; r.a = m_addr; r.d = w[DW-1:0];
        pq.push_back(r);
      end
    end
    if (acc && op == 2'b10) begin
      m_addr = w[AW-1:0];
      m_inc = w[DW-1];
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, 0, '0);
  endtask
  initial begin
    logic [1:0] op;
    logic [DW-1:0] pl;
    logic st, ak, er, cs;
    n_cmp = 0; n_bad = 0;
    rst_n = 0; cmd_stb = 0; cmd_word = '0; wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rdata = '0;
    reset_model();
    #3 rst_checks("rst0");
    @(negedge clk) rst_n = 1;
    // single write to address 1
    step(1, cw(2'b10, 32'd1), 0, 0, 0, '0);
    step(1, cw(2'b01, 32'd5), 0, 0, 0, '0);
    idle(1);
    step(0, '0, 0, 1, 0, '0);
    idle(2);
    // single read returning 5
    step(1, cw(2'b10, 32'd1), 0, 0, 0, '0);
    step(1, cw(2'b00, 32'd0), 0, 0, 0, '0);
    idle(1);
    step(0, '0, 0, 1, 0, 32'd5);
    idle(2);
    // four auto-increment reads from 0x10, acks held back until the limit is reached
    step(1, cw(2'b10, 32'h8000_0010), 0, 0, 0, '0);
    for (int k = 0; k < 12; k++) step(k < 6, cw(2'b00, '0), 0, k >= 5 && oq.size() > 0, 0, $urandom);
    idle(2);
    // stall held three cycles on the second request
    step(1, cw(2'b10, 32'h20), 0, 0, 0, '0);
    for (int k = 0; k < 10; k++)
      step(k < 6, cw(2'b01, k == 0 ? 32'hA : k == 1 ? 32'hB : 32'hC), k >= 2 && k <= 4, oq.size() > 0, 0, '0);
    idle(2);
    // err on the second of three outstanding reads, then late acks
    step(1, cw(2'b10, 32'h8000_0030), 0, 0, 0, '0);
    for (int k = 0; k < 8; k++) step(k < 3 || k == 6, cw(2'b00, '0), 0, k == 4 || k >= 6, k == 5, $urandom);
    // timeout with no ack, then a late ack
    step(1, cw(2'b00, '0), 0, 0, 0, '0);
    idle(12);
    step(0, '0, 0, 1, 0, $urandom);
    idle(2);
    // abort while stalled and busy
    step(1, cw(2'b01, 32'hABCD), 0, 0, 0, '0);
    step(0, '0, 1, 0, 0, '0);
    step(1, cw(2'b11, '0), 1, 0, 0, '0);
    idle(1);
    step(0, '0, 0, 1, 0, '0);
    idle(2);
    // address wrap with auto-increment
    step(1, cw(2'b10, 32'hBFFF_FFFF), 0, 0, 0, '0);
    step(1, cw(2'b01, 32'd1), 0, 0, 0, '0);
    step(1, cw(2'b01, 32'd2), 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(0, '0, 0, oq.size() > 0, 0, '0);
    // reset with two outstanding reads
    step(1, cw(2'b00, '0), 0, 0, 0, '0);
    step(1, cw(2'b00, '0), 0, 0, 0, '0);
    idle(1);
    check("two_outstanding", 64'(oq.size()), 64'd2);
    @(negedge clk);
    #2 rst_n = 0; cmd_stb = 0; wb_ack = 0; wb_err = 0; wb_stall = 0;
    #1 rst_checks("rst_mid");
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    reset_model();
    for (int k = 0; k < 3; k++) step(0, '0, 0, 1, 0, $urandom);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      st = $urandom_range(3) == 0;
      ak = oq.size() > 0 ? $urandom_range(2) != 0 : (pq.size() == 0 && $urandom_range(7) == 0);
      er = $urandom_range(59) == 0;
      cs = $urandom_range(9) < 6;
      op = 2'($urandom_range(2));
      if ($urandom_range(49) == 0) op = 2'b11;
      pl = $urandom;
      if (op == 2'b10 && $urandom_range(3) == 0) pl[AW-1:0] = {{(AW-2){1'b1}}, 2'($urandom_range(3))};
      step(cs, cw(op, pl), st, ak, er, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_pipe_master.md
WB_PIPE_MASTER -- requirements
Module: wb_pipe_master

Interface
REQ-001 The module SHALL have parameter AW, default 30, meaning Wishbone word-address width.
REQ-002 The module SHALL have parameter DW, default 32, meaning Wishbone data width; legal values are 8, 16, 32 and 64, with AW < DW.
REQ-003 The module SHALL have parameter MAX_OUT, default 4, meaning maximum outstanding (issued, unacknowledged) transfers; legal range is 1..15.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, meaning cycles without ack/err before abort; 0 disables the timeout.
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_cmd_stb  in  1  command valid.
REQ-008 i_cmd_word  in  DW+2  command: [DW+1:DW] opcode, [DW-1:0] payload.
REQ-009 o_cmd_busy  out  1  command not accepted this cycle.
REQ-010 o_rsp_stb  out  1  response valid, one-cycle pulse.
REQ-011 o_rsp_word  out  DW+2  response: [DW+1:DW] type, [DW-1:0] payload.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined-mode master controls.
REQ-013 o_wb_addr  out  AW  word address.
REQ-014 o_wb_data  out  DW  write data.
REQ-015 o_wb_sel  out  DW/8  byte select.
REQ-016 i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave responses.
REQ-017 i_wb_data  in  DW  read data.

Function
REQ-018 A command SHALL be accepted when i_cmd_stb=1 and o_cmd_busy=0 on the same edge; commands presented while busy are ignored and not queued.
REQ-019 Opcode 2'b10 (set address): the address register SHALL load payload[AW-1:0] and the auto-increment flag SHALL load payload[DW-1]; no bus cycle is generated and no response is emitted.
REQ-020 Opcode 2'b01 (write) and 2'b00 (read) SHALL issue one bus request: in the cycle after acceptance, o_wb_cyc=1, o_wb_stb=1, o_wb_we=opcode[0], o_wb_addr=address register, o_wb_data=payload for writes, o_wb_sel all ones.
REQ-021 Opcode 2'b11 (abort) SHALL be accepted even while busy; it SHALL drop cyc and stb on the next edge, clear the outstanding count, and emit response type 2'b11 with payload 0.
REQ-022 o_wb_stb and all request fields SHALL hold constant while i_wb_stall=1; the request is issued on the edge where stb=1 and stall=0.
REQ-023 On each issued request with auto-increment set, the address register SHALL increment by 1, wrapping modulo 2^AW.
REQ-024 The outstanding counter SHALL increment on issue and decrement on ack; simultaneous issue and ack SHALL leave it unchanged.
REQ-025 o_cmd_busy SHALL be 1 when (stb=1 and stall=1), when issue would make outstanding exceed MAX_OUT, or in the cycle after err/timeout; it is 0 otherwise.
REQ-026 Each ack SHALL produce, one cycle later, o_rsp_stb=1 with type 2'b01 (write, payload 0) or 2'b00 (read, payload=i_wb_data), in issue order; ack type is tracked per transfer in a MAX_OUT-deep shift/FIFO of we bits.
REQ-027 o_wb_cyc SHALL deassert on the edge after the last outstanding ack when no request is pending or being accepted; back-to-back commands keep cyc high.
REQ-028 i_wb_err while cyc=1 SHALL, on the next edge, drop cyc and stb, clear outstanding, and emit a single type 2'b10 response with payload[AW-1:0]=address of the errored transfer.
REQ-029 With TIMEOUT>0, a counter SHALL count cycles with outstanding>0 or stb=1 and no ack/err, reset on any ack; reaching TIMEOUT SHALL act as REQ-028 with payload all ones.
REQ-030 Acks arriving with cyc=0 SHALL be ignored.

Reset
REQ-031 While i_reset_n=0: cyc, stb, we, rsp_stb, cmd_busy=0; addr, data, rsp_word, outstanding, timeout counter, and auto-increment flag=0; sel all ones.
REQ-032 Reset mid-transfer SHALL drop cyc immediately (asynchronously) and discard all pending responses.

Verification
REQ-033 Set addr 1, write 5 -> one cycle with we=1, addr=1, data=5; rsp type 01 one cycle after ack.
REQ-034 Set addr 1, read, slave returns 5 -> rsp type 00, payload 5; cyc low the cycle after ack.
REQ-035 Set addr 0x10 with auto-increment, 4 reads back-to-back, slave acks 1 cycle late -> addrs 0x10..0x13, busy at 4 outstanding, 4 in-order rsps, cyc continuous.
REQ-036 Stall held for 3 cycles on the 2nd request -> stb/addr stable, busy=1 for 3 cycles, no lost or duplicated transfer.
REQ-037 Err on the 2nd of 3 outstanding, then separately no ack with TIMEOUT=8 -> one type 10 rsp each (payload=addr and all ones respectively), cyc dropped, late acks ignored.
REQ-038 i_reset_n low with 2 outstanding -> all outputs at REQ-031 values the same cycle; no rsp after release.
